// File: rtl/memory_controller.sv
// Single-access controller for a small word-addressed memory unit: registers a request,
// walks the unit through setup/strobe/hold and returns read data on a ready/valid port.
module memory_controller #(
    parameter int STROBE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       mem_op,
    output logic       mem_select,
    output logic [2:0] mem_address,
    output logic [7:0] mem_in_bus,
    input  logic [7:0] mem_out_bus
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;
    logic       op_q, op_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The request registers double as the memory-side drivers, so they hold between accesses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = SETUP;
                    op_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = STROBE_LOAD;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    if (op_q) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RESP;
                        rdata_d = mem_out_bus;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready rises one edge after settling in IDLE, which spaces accesses and delays the first accept after reset.
        ready_d = (state_q == IDLE) && (state_d == IDLE);
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign mem_select  = (state_q == STROBE);
    assign mem_op      = op_q;
    assign mem_address = addr_q;
    assign mem_in_bus  = wdata_q;

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: two instances (STROBE_CYCLES 1 and 3), each with its own
// memory unit and a cycle-level access model, plus directed accesses with literal expectations.
module tb_memory_controller;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       req_valid   [2];
    logic       req_we      [2];
    logic [2:0] req_addr    [2];
    logic [7:0] req_wdata   [2];
    logic       rsp_ready   [2];
    logic       req_ready   [2];
    logic       rsp_valid   [2];
    logic [7:0] rsp_rdata   [2];
    logic       mem_op      [2];
    logic       mem_select  [2];
    logic [2:0] mem_address [2];
    logic [7:0] mem_in_bus  [2];
    logic [7:0] mem_out_bus [2];

    logic [7:0] mem_arr [2][8];

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    // Access model state, advanced once per rising edge
    bit         m_active [2];
    bit         m_resp   [2];
    int         m_age    [2];
    int         m_idle   [2];
    logic       m_op     [2];
    logic [2:0] m_addr   [2];
    logic [7:0] m_data   [2];
    logic [7:0] m_rdata  [2];

    always #5 clk = ~clk;

    memory_controller #(.STROBE_CYCLES(S0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .mem_op(mem_op[0]), .mem_select(mem_select[0]), .mem_address(mem_address[0]),
        .mem_in_bus(mem_in_bus[0]), .mem_out_bus(mem_out_bus[0])
    );

    memory_controller #(.STROBE_CYCLES(S1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .mem_op(mem_op[1]), .mem_select(mem_select[1]), .mem_address(mem_address[1]),
        .mem_in_bus(mem_in_bus[1]), .mem_out_bus(mem_out_bus[1])
    );

    // Memory units: write on a selected edge, read data always presented
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_select[d] && mem_op[d]) mem_arr[d][mem_address[d]] <= mem_in_bus[d];
        end
    end
    assign mem_out_bus[0] = mem_arr[0][mem_address[0]];
    assign mem_out_bus[1] = mem_arr[1][mem_address[1]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int s_of(input int d);
        return (d == 0) ? S0 : S1;
    endfunction

    // Model: age counts edges since accept; strobe is ages 1..S, read data lands at age S+1,
    // a write retires at age S+2, and ready needs one full idle edge.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_active[d] <= 1'b0;
                m_resp[d]   <= 1'b0;
                m_age[d]    <= 0;
                m_idle[d]   <= 0;
                m_op[d]     <= 1'b0;
                m_addr[d]   <= '0;
                m_data[d]   <= '0;
                m_rdata[d]  <= '0;
            end else if (!m_active[d]) begin
                if (req_valid[d] && m_idle[d] >= 1) begin
                    m_active[d] <= 1'b1;
                    m_age[d]    <= 0;
                    m_idle[d]   <= 0;
                    m_op[d]     <= req_we[d];
                    m_addr[d]   <= req_addr[d];
                    m_data[d]   <= req_wdata[d];
                end else if (m_idle[d] < 2) begin
                    m_idle[d] <= m_idle[d] + 1;
                end
            end else if (m_resp[d]) begin
                if (rsp_ready[d]) begin
                    m_active[d] <= 1'b0;
                    m_resp[d]   <= 1'b0;
                    m_idle[d]   <= 0;
                end
            end else begin
                m_age[d] <= m_age[d] + 1;
                if (!m_op[d] && m_age[d] == s_of(d)) begin
                    m_rdata[d] <= mem_arr[d][m_addr[d]];
                    m_resp[d]  <= 1'b1;
                end else if (m_op[d] && m_age[d] == s_of(d) + 1) begin
                    m_active[d] <= 1'b0;
                    m_idle[d]   <= 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int d, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s dut%0d: got %0h, want %0h (t=%0t)", name, d, act, exp, $time);
        else
            passes++;
    endtask

    task automatic compareLoop();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int s;
                s = s_of(d);
                checkOutput("req_ready", d, 32'(req_ready[d]), 32'(!m_active[d] && m_idle[d] >= 1));
                checkOutput("rsp_valid", d, 32'(rsp_valid[d]), 32'(m_resp[d]));
                checkOutput("mem_select", d, 32'(mem_select[d]),
                            32'(m_active[d] && !m_resp[d] && m_age[d] >= 1 && m_age[d] <= s));
                checkOutput("mem_op", d, 32'(mem_op[d]), 32'(m_op[d]));
                checkOutput("mem_address", d, 32'(mem_address[d]), 32'(m_addr[d]));
                checkOutput("mem_in_bus", d, 32'(mem_in_bus[d]), 32'(m_data[d]));
                checkOutput("rsp_rdata", d, 32'(rsp_rdata[d]), 32'(m_rdata[d]));
            end
        end
    endtask

    // One access on instance d; entered and left on a falling edge
    task automatic applyStimulus(input int d, input logic we, input logic [2:0] addr,
                                 input logic [7:0] data, input int stall, input bit toggle,
                                 output int lat, output logic [7:0] rdata, output int sel_n);
        int  w;
        int  acc;
        int  held;
        int  vcnt;
        bit  seen;
        bit  done;
        lat = -1; rdata = 8'h00; sel_n = 0;
        held = 0; vcnt = 0; seen = 0; done = 0; w = 0;
        req_we[d] = we; req_addr[d] = addr; req_wdata[d] = data; req_valid[d] = 1'b1;
        rsp_ready[d] = (stall == 0);
        while (!req_ready[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready[d]) begin
            checkOutput("accept_timeout", d, 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            if (toggle) begin
                req_addr[d]  = req_addr[d] + 3'd3;
                req_wdata[d] = ~req_wdata[d] + 8'd7;
                req_we[d]    = ~req_we[d];
            end
            if (mem_select[d]) begin
                sel_n++;
                checkOutput("strobe_addr", d, 32'(mem_address[d]), 32'(addr));
                checkOutput("strobe_data", d, 32'(mem_in_bus[d]), 32'(data));
                checkOutput("strobe_op", d, 32'(mem_op[d]), 32'(we));
            end
            if (we) begin
                if (req_ready[d]) begin
                    lat = cyc - acc;
                    done = 1;
                end
            end else begin
                if (rsp_valid[d]) begin
                    vcnt++;
                    if (!seen) begin
                        seen = 1;
                        lat = cyc - acc;
                        rdata = rsp_rdata[d];
                    end else begin
                        checkOutput("rdata_stable", d, 32'(rsp_rdata[d]), 32'(rdata));
                        checkOutput("ready_low_in_resp", d, 32'(req_ready[d]), 32'd0);
                    end
                    if (held == stall) rsp_ready[d] = 1'b1;
                    held++;
                end else if (seen && req_ready[d]) begin
                    done = 1;
                end
            end
            @(negedge clk);
        end
        checkOutput("access_done", d, 32'(done), 32'd1);
        if (!we) checkOutput("valid_cycles", d, 32'(vcnt), 32'(stall + 1));
        rsp_ready[d] = 1'b0;
        req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int sel_n;
        int w;
        logic [7:0] rd;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; rsp_ready[d] = 1'b0;
        end
        fork
            compareLoop();
        join_none

        // Asynchronous reset, released between edges
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_req_ready", d, 32'(req_ready[d]), 32'd0);
            checkOutput("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
            checkOutput("rst_mem_select", d, 32'(mem_select[d]), 32'd0);
            checkOutput("rst_mem_address", d, 32'(mem_address[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("ready_at_release", 0, 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        checkOutput("ready_first_edge", 0, 32'(req_ready[0]), 32'd1);
        checkOutput("ready_first_edge", 1, 32'(req_ready[1]), 32'd1);

        // STROBE_CYCLES = 1: write, read back, stalled read, toggled inputs
        applyStimulus(0, 1'b1, 3'd5, 8'hA5, 0, 1'b0, lat, rd, sel_n);
        checkOutput("wr_latency", 0, 32'(lat), 32'd4);
        checkOutput("wr_sel_cycles", 0, 32'(sel_n), 32'd1);
        applyStimulus(0, 1'b0, 3'd5, 8'h00, 0, 1'b0, lat, rd, sel_n);
        checkOutput("rd_data", 0, 32'(rd), 32'hA5);
        checkOutput("rd_latency", 0, 32'(lat), 32'd2);
        checkOutput("rd_sel_cycles", 0, 32'(sel_n), 32'd1);
        applyStimulus(0, 1'b0, 3'd5, 8'h5A, 5, 1'b0, lat, rd, sel_n);
        checkOutput("stall_rd_data", 0, 32'(rd), 32'hA5);
        applyStimulus(0, 1'b1, 3'd2, 8'h3C, 0, 1'b1, lat, rd, sel_n);
        checkOutput("toggle_wr_latency", 0, 32'(lat), 32'd4);
        applyStimulus(0, 1'b0, 3'd2, 8'h00, 2, 1'b1, lat, rd, sel_n);
        checkOutput("toggle_rd_data", 0, 32'(rd), 32'h3C);

        // STROBE_CYCLES = 3: fill all addresses, then read them back
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1, 1'b1, 3'(a), 8'(a * 17), 0, a[0], lat, rd, sel_n);
            checkOutput("fill_wr_latency", 1, 32'(lat), 32'd6);
            checkOutput("fill_sel_cycles", 1, 32'(sel_n), 32'd3);
        end
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1, 1'b0, 3'(a), 8'h00, a % 3, a[0], lat, rd, sel_n);
            checkOutput("fill_rd_data", 1, 32'(rd), 32'(8'(a * 17)));
            checkOutput("fill_rd_latency", 1, 32'(lat), 32'd4);
            checkOutput("fill_rd_sel_cycles", 1, 32'(sel_n), 32'd3);
        end

        // Reset in the middle of a read strobe abandons the access
        req_we[1] = 1'b0; req_addr[1] = 3'd6; req_wdata[1] = 8'h00; req_valid[1] = 1'b1;
        w = 0;
        while (!req_ready[1] && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        checkOutput("strobe_before_reset", 1, 32'(mem_select[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("sel_async_drop", 1, 32'(mem_select[1]), 32'd0);
        checkOutput("rsp_valid_in_reset", 1, 32'(rsp_valid[1]), 32'd0);
        checkOutput("ready_in_reset", 1, 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkOutput("no_rsp_after_reset", 1, 32'(rsp_valid[1]), 32'd0);
        end
        checkOutput("ready_after_reset", 1, 32'(req_ready[1]), 32'd1);
        checkOutput("ready_after_reset", 0, 32'(req_ready[0]), 32'd1);

        applyStimulus(1, 1'b0, 3'd4, 8'h00, 1, 1'b0, lat, rd, sel_n);
        checkOutput("post_reset_rd_data", 1, 32'(rd), 32'h44);

        repeat (2) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
